// File: rtl/tilemap_addr_gen.sv
// -----------------------------------------------------------------------------
// tilemap_addr_gen
//   Scroll and address generator for a multi-layer tilemap video pipeline.
//   It keeps the beam H/V counters and the double-buffered per-layer scroll
//   registers. It time-multiplexes tile RAM fetches across the layers. It
//   stages the fetched index/attribute bytes and produces the tile graphics
//   PROM address for each layer.
//
// Ports
//   CLK_6M  in   pixel clock, all state on rising edge
//   nRST    in   asynchronous active-low reset
//   nHSYNC  in   horizontal sync, active-low
//   nVSYNC  in   vertical sync, active-low
//   FLIP    in   horizontal mirror of the beam position
//   nLATCH  in   CPU scroll register write strobe, active-low
//   CA      in   CPU address {layer, reg[1:0]}
//   CD      in   CPU write data
//   RD      in   tile RAM read data
//   RA      out  tile RAM address {layer, row[4:0], col[5:0], byte}
//   GA      out  tile PROM address {attr[1:0], index[7:0], tilerow[2:0], nibble}
//   H2      out  per-layer scrolled-x bit 2 (nibble phase)
// -----------------------------------------------------------------------------
module tilemap_addr_gen #(
  parameter int                    NUM_LAYERS      = 2,
  parameter int                    H_TOTAL         = 384,
  parameter logic [NUM_LAYERS-1:0] AUTOSCROLL_MASK = '0,
  localparam int                   LW              = $clog2(NUM_LAYERS)
) (
  input  logic                  CLK_6M,
  input  logic                  nRST,
  input  logic                  nHSYNC,
  input  logic                  nVSYNC,
  input  logic                  FLIP,
  input  logic                  nLATCH,
  input  logic [LW+1:0]         CA,
  input  logic [7:0]            CD,
  input  logic [7:0]            RD,
  output logic [LW+11:0]        RA,
  output logic [13:0]           GA,
  output logic [NUM_LAYERS-1:0] H2
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);

  // Beam counters and sync history
  logic [8:0] h_q, v_q;
  logic       hs_q, vs_q;
  logic       hs_fall, vs_fall;

  // Scroll registers: pending (CPU side) and active (current frame)
  logic [8:0] pend_h_q   [NUM_LAYERS];
  logic [8:0] pend_h_d   [NUM_LAYERS];
  logic [7:0] pend_v_q   [NUM_LAYERS];
  logic [7:0] pend_v_d   [NUM_LAYERS];
  logic [2:0] pend_pri_q [NUM_LAYERS];
  logic [2:0] pend_pri_d [NUM_LAYERS];
  logic [8:0] act_h_q    [NUM_LAYERS];
  logic [7:0] act_v_q    [NUM_LAYERS];
  logic [2:0] act_pri_q  [NUM_LAYERS];
  logic       cpu_h_wr   [NUM_LAYERS];

  // Scrolled coordinates
  logic [8:0] eh;
  logic [8:0] sx [NUM_LAYERS];
  logic [7:0] sy [NUM_LAYERS];

  // Fetch pipeline
  logic [2:0]    phase;
  logic [LW-1:0] fetch_layer;
  logic [LW-1:0] ga_layer;
  logic [LW+11:0] ra_d, ra_q;
  logic [LW-1:0] ra_layer_q;
  logic          ra_byte_q;
  logic [7:0]    stg_idx_q  [NUM_LAYERS];
  logic [1:0]    stg_attr_q [NUM_LAYERS];
  logic [9:0]    shadow_q   [NUM_LAYERS];
  logic [2:0]    sx_lo_q    [NUM_LAYERS];
  logic [13:0]   ga_d, ga_q;
  logic [NUM_LAYERS-1:0] h2_d, h2_q;

  // Priority is held for a downstream mixer and V[8] has no consumer here.
  logic unused_bits;

  assign hs_fall = hs_q & ~nHSYNC;
  assign vs_fall = vs_q & ~nVSYNC;

  assign eh          = FLIP ? (H_LAST - h_q) : h_q;
  assign phase       = h_q[2:0];
  // For two layers phase[1] alone selects the layer, so phases 4-7 repeat 0-3.
  assign fetch_layer = phase[LW:1];
  assign ga_layer    = h_q[LW-1:0];

  always_comb begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      sx[l] = act_h_q[l] + eh;
      sy[l] = act_v_q[l] + v_q[7:0];
    end
  end

  // CPU write decode merged into pending state. Auto-scroll increments the
  // pending hscroll at frame start unless the CPU writes that hscroll in the
  // same clock, in which case the CPU value is taken as is.
  always_comb begin
    for (int l = 0; l < NUM_LAYERS; l++) begin
      pend_h_d[l]   = pend_h_q[l];
      pend_v_d[l]   = pend_v_q[l];
      pend_pri_d[l] = pend_pri_q[l];
      cpu_h_wr[l]   = 1'b0;
      if (!nLATCH && (CA[LW+1:2] == LW'(l))) begin
        case (CA[1:0])
          2'b00: begin
            pend_h_d[l][7:0] = CD;
            cpu_h_wr[l]      = 1'b1;
          end
          2'b01: begin
            pend_h_d[l][8] = CD[0];
            pend_pri_d[l]  = CD[3:1];
            cpu_h_wr[l]    = 1'b1;
          end
          2'b10:   pend_v_d[l] = CD;
          default: ;
        endcase
      end
      if (vs_fall && AUTOSCROLL_MASK[l] && !cpu_h_wr[l]) begin
        pend_h_d[l] = pend_h_q[l] + 9'd1;
      end
    end
  end

  always_comb begin
    ra_d = {fetch_layer, sy[fetch_layer][7:3], sx[fetch_layer][8:3], phase[0]};
    ga_d = {shadow_q[ga_layer], sy[ga_layer][2:0], sx[ga_layer][2]};
    for (int l = 0; l < NUM_LAYERS; l++) h2_d[l] = sx[l][2];
  end

  always_comb begin
    unused_bits = v_q[8];
    for (int l = 0; l < NUM_LAYERS; l++) unused_bits = unused_bits ^ (^act_pri_q[l]);
  end

  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      h_q        <= '0;
      v_q        <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      ra_q       <= '0;
      ra_layer_q <= '0;
      ra_byte_q  <= 1'b0;
      ga_q       <= '0;
      h2_q       <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        pend_h_q[l]   <= '0;
        pend_v_q[l]   <= '0;
        pend_pri_q[l] <= '0;
        act_h_q[l]    <= '0;
        act_v_q[l]    <= '0;
        act_pri_q[l]  <= '0;
        stg_idx_q[l]  <= '0;
        stg_attr_q[l] <= '0;
        shadow_q[l]   <= '0;
        sx_lo_q[l]    <= '0;
      end
    end else begin
      hs_q <= nHSYNC;
      vs_q <= nVSYNC;
      h_q  <= hs_fall ? 9'd0 : h_q + 9'd1;
      if (vs_fall)      v_q <= 9'd0;
      else if (hs_fall) v_q <= v_q + 9'd1;

      for (int l = 0; l < NUM_LAYERS; l++) begin
        pend_h_q[l]   <= pend_h_d[l];
        pend_v_q[l]   <= pend_v_d[l];
        pend_pri_q[l] <= pend_pri_d[l];
        if (vs_fall) begin
          act_h_q[l]   <= pend_h_d[l];
          act_v_q[l]   <= pend_v_d[l];
          act_pri_q[l] <= pend_pri_d[l];
        end
        // Staged bytes become visible only when this layer crosses a tile edge.
        sx_lo_q[l] <= sx[l][2:0];
        if (sx_lo_q[l] == 3'd7 && sx[l][2:0] == 3'd0) begin
          shadow_q[l] <= {stg_attr_q[l], stg_idx_q[l]};
        end
      end

      // RD belongs to the address presented on the previous clock.
      if (!ra_byte_q) stg_idx_q[ra_layer_q]  <= RD;
      else            stg_attr_q[ra_layer_q] <= RD[1:0];

      ra_q       <= ra_d;
      ra_layer_q <= fetch_layer;
      ra_byte_q  <= phase[0];
      ga_q       <= ga_d;
      h2_q       <= h2_d;
    end
  end

  assign RA = ra_q;
  assign GA = ga_q;
  assign H2 = h2_q;

endmodule
